// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the IF/ID hazard sequencer: opcodes, FSM encoding,
// register-index width and the operand-usage decode.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DISCARD = 2'd2
  } hz_state_e;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_S || op == OP_B);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of the pipeline-status inputs and sequencing outputs of hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
) ();
  import hazard_ctrl_pkg::*;

  logic [6:0]                IF_ID_inst_opcode;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
  logic                      ID_EX_mem_read;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
  logic                      ex_branch_taken;
  logic                      dmem_busy;
  logic                      imem_ready;
  logic                      imem_req;
  logic                      pc_write;
  logic                      IF_ID_write;
  logic                      IF_flush;
  logic                      ID_EX_flush;
  logic                      pipe_hold;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      redirect_count;

  modport master (
    output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_read, ID_EX_rd,
           ex_branch_taken, dmem_busy, imem_ready,
    input  imem_req, pc_write, IF_ID_write, IF_flush, ID_EX_flush, pipe_hold,
           stall_cycles, redirect_count
  );

  modport slave (
    input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_mem_read, ID_EX_rd,
           ex_branch_taken, dmem_busy, imem_ready,
    output imem_req, pc_write, IF_ID_write, IF_flush, ID_EX_flush, pipe_hold,
           stall_cycles, redirect_count
  );

endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [6:0]                opcode_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
  input  logic                      mem_read_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_i,
  output logic                      lu_o
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = (rd_i == rs1_i) && uses_rs1(opcode_i);
  assign hit_rs2 = (rd_i == rs2_i) && uses_rs2(opcode_i);
  assign lu_o    = mem_read_i && (rd_i != '0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// IF/ID front-end sequencer: boot flush, stall arbitration, stale-fetch
// discard after redirects, and saturating stall/redirect counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  hz_state_e            state_q, state_d;
  logic [3:0]           boot_cnt_q, boot_cnt_d;
  logic [CNT_WIDTH-1:0] stall_q, redir_q;

  logic lu;
  logic imem_req_c, pc_write_c, if_id_write_c, if_flush_c, id_ex_flush_c, pipe_hold_c;
  logic redirect_c;

  load_use_detect u_lu (
    .opcode_i   (hz.IF_ID_inst_opcode),
    .rs1_i      (hz.IF_ID_rs1),
    .rs2_i      (hz.IF_ID_rs2),
    .mem_read_i (hz.ID_EX_mem_read),
    .rd_i       (hz.ID_EX_rd),
    .lu_o       (lu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_INIT;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == 4'd0) state_d = ST_RUN;
        else                    boot_cnt_d = boot_cnt_q - 4'd1;
      end
      ST_RUN, ST_DISCARD: begin
        // A frozen MEM stage holds everything, including any pending discard.
        if (!hz.dmem_busy) begin
          if (hz.ex_branch_taken)
            state_d = (!hz.imem_ready || state_q == ST_DISCARD) ? ST_DISCARD : ST_RUN;
          else if (state_q == ST_DISCARD && hz.imem_ready)
            state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    imem_req_c    = 1'b0;
    pc_write_c    = 1'b0;
    if_id_write_c = 1'b0;
    if_flush_c    = 1'b0;
    id_ex_flush_c = 1'b0;
    pipe_hold_c   = 1'b0;
    redirect_c    = 1'b0;
    unique case (state_q)
      ST_BOOT: begin
        if_flush_c    = 1'b1;
        id_ex_flush_c = 1'b1;
      end
      ST_RUN, ST_DISCARD: begin
        imem_req_c = 1'b1;
        if (hz.dmem_busy) begin
          pipe_hold_c = 1'b1;
          imem_req_c  = 1'b0;
        end else if (hz.ex_branch_taken) begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
          if_flush_c    = 1'b1;
          id_ex_flush_c = 1'b1;
          redirect_c    = 1'b1;
        end else if (state_q == ST_DISCARD) begin
          if_flush_c = 1'b1;
        end else if (lu) begin
          id_ex_flush_c = 1'b1;
        end else if (!hz.imem_ready) begin
          if_id_write_c = 1'b1;
          if_flush_c    = 1'b1;
        end else begin
          pc_write_c    = 1'b1;
          if_id_write_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (state_q != ST_BOOT && !pc_write_c && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (redirect_c && redir_q != '1)
        redir_q <= redir_q + 1'b1;
    end
  end

  assign hz.imem_req       = imem_req_c;
  assign hz.pc_write       = pc_write_c;
  assign hz.IF_ID_write    = if_id_write_c;
  assign hz.IF_flush       = if_flush_c;
  assign hz.ID_EX_flush    = id_ex_flush_c;
  assign hz.pipe_hold      = pipe_hold_c;
  assign hz.stall_cycles   = stall_q;
  assign hz.redirect_count = redir_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a rule-level reference model.
module tb_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int CNT_WIDTH   = 32;

  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;

  logic clk = 1'b0;
  logic reset;

  hazard_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) hz ();

  hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: boot cycles still to run, pending stale fetch, counters.
  int      boot_left;
  bit      discarding;
  longint  m_stall;
  longint  m_redir;
  localparam longint SAT = (64'd1 << CNT_WIDTH) - 1;

  function automatic bit model_lu(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                                  input bit mr, input logic [4:0] rd);
    bit r1 = 1'b1;
    bit r2 = 1'b0;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: r1 = 1'b0;
      default: r1 = 1'b1;
    endcase
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: r2 = 1'b1;
      default: r2 = 1'b0;
    endcase
    return mr && rd != 0 && ((rd == rs1 && r1) || (rd == rs2 && r2));
  endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic vec(input string nm, input bit r, input logic [6:0] op, input logic [4:0] rs1,
                     input logic [4:0] rs2, input bit mr, input logic [4:0] rd,
                     input bit br, input bit dm, input bit rdy);
    bit e_req, e_pcw, e_ifw, e_iff, e_idf, e_hold, lu;
    reset = r;
    hz.IF_ID_inst_opcode = op;
    hz.IF_ID_rs1 = rs1;
    hz.IF_ID_rs2 = rs2;
    hz.ID_EX_mem_read = mr;
    hz.ID_EX_rd = rd;
    hz.ex_branch_taken = br;
    hz.dmem_busy = dm;
    hz.imem_ready = rdy;
    #4;
    lu = model_lu(op, rs1, rs2, mr, rd);
    {e_req, e_pcw, e_ifw, e_iff, e_idf, e_hold} = 6'b0;
    if (boot_left > 0)   begin e_iff = 1; e_idf = 1; end
    else if (dm)         e_hold = 1;
    else if (br)         begin e_req = 1; e_pcw = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
    else if (discarding) begin e_req = 1; e_iff = 1; end
    else if (lu)         begin e_req = 1; e_idf = 1; end
    else if (!rdy)       begin e_req = 1; e_ifw = 1; e_iff = 1; end
    else                 begin e_req = 1; e_pcw = 1; e_ifw = 1; end
    n_vec++;
    cmp({nm, " imem_req"},    hz.imem_req,    e_req);
    cmp({nm, " pc_write"},    hz.pc_write,    e_pcw);
    cmp({nm, " IF_ID_write"}, hz.IF_ID_write, e_ifw);
    cmp({nm, " IF_flush"},    hz.IF_flush,    e_iff);
    cmp({nm, " ID_EX_flush"}, hz.ID_EX_flush, e_idf);
    cmp({nm, " pipe_hold"},   hz.pipe_hold,   e_hold);
    cmp({nm, " stall_cycles"},   hz.stall_cycles,   m_stall);
    cmp({nm, " redirect_count"}, hz.redirect_count, m_redir);
    $display("vec %0d %s: req=%0b pcw=%0b ifw=%0b iff=%0b idf=%0b hold=%0b stall=%0d redir=%0d",
             n_vec, nm, hz.imem_req, hz.pc_write, hz.IF_ID_write, hz.IF_flush,
             hz.ID_EX_flush, hz.pipe_hold, hz.stall_cycles, hz.redirect_count);
    if (r) begin
      boot_left = BOOT_CYCLES; discarding = 0; m_stall = 0; m_redir = 0;
    end else if (boot_left > 0) begin
      boot_left--;
    end else begin
      if (!e_pcw && m_stall < SAT) m_stall++;
      if (!dm && br) begin
        if (m_redir < SAT) m_redir++;
        discarding = discarding || !rdy;
      end else if (!dm && discarding && rdy) begin
        discarding = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    hz.IF_ID_inst_opcode = OPC_I;
    hz.IF_ID_rs1 = 0; hz.IF_ID_rs2 = 0; hz.ID_EX_mem_read = 0; hz.ID_EX_rd = 0;
    hz.ex_branch_taken = 0; hz.dmem_busy = 0; hz.imem_ready = 1;
    @(posedge clk);
    #1;
    boot_left = BOOT_CYCLES; discarding = 0; m_stall = 0; m_redir = 0;
    reset = 1'b0;
    #1;
    cmp("boot imem_req literal", hz.imem_req, 0);
    cmp("boot IF_flush literal", hz.IF_flush, 1);

    vec("boot0",  0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    vec("boot1",  0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    vec("run0",   0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    cmp("after boot stall literal", hz.stall_cycles, 0);
    cmp("after boot redir literal", hz.redirect_count, 0);

    vec("lu_r_rs2",  0, OPC_R,   1, 5, 1, 5, 0, 0, 1);
    cmp("lu stall literal", hz.stall_cycles, 1);
    vec("lu_lui",    0, OPC_LUI, 5, 0, 1, 5, 0, 0, 1);
    vec("lu_rd0",    0, OPC_R,   0, 0, 1, 0, 0, 0, 1);
    cmp("no-lu stall literal", hz.stall_cycles, 1);

    for (int i = 0; i < 3; i++) vec("imem_wait", 0, OPC_I, 0, 0, 0, 0, 0, 0, 0);
    vec("imem_back", 0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    cmp("imem wait stall literal", hz.stall_cycles, 4);

    vec("br_nrdy",   0, OPC_I, 0, 0, 0, 0, 1, 0, 0);
    vec("disc_wait", 0, OPC_I, 0, 0, 0, 0, 0, 0, 0);
    vec("disc_drop", 0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    vec("resume",    0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    cmp("redirect literal", hz.redirect_count, 1);
    cmp("discard stall literal", hz.stall_cycles, 6);

    vec("br_nrdy2",  0, OPC_I, 0, 0, 0, 0, 1, 0, 0);
    vec("br_in_disc",0, OPC_I, 0, 0, 0, 0, 1, 0, 1);
    vec("disc_lu",   0, OPC_R, 3, 3, 1, 3, 0, 0, 1);
    vec("resume2",   0, OPC_I, 0, 0, 0, 0, 0, 0, 1);

    vec("dmem_all",  0, OPC_R, 7, 7, 1, 7, 1, 1, 1);
    cmp("dmem pipe_hold literal", hz.pipe_hold, 1);
    vec("br_release",0, OPC_I, 0, 0, 0, 0, 1, 0, 1);
    vec("resume3",   0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    cmp("redirect literal 4", hz.redirect_count, 4);

    vec("br_nrdy3",  0, OPC_I, 0, 0, 0, 0, 1, 0, 0);
    vec("rst_disc",  1, OPC_I, 0, 0, 0, 0, 0, 0, 0);
    cmp("reset stall literal", hz.stall_cycles, 0);
    cmp("reset redir literal", hz.redirect_count, 0);
    cmp("reset imem_req literal", hz.imem_req, 0);
    vec("reboot0",   0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    vec("reboot1",   0, OPC_I, 0, 0, 0, 0, 0, 0, 1);
    #1;
    cmp("post-boot pc_write literal", hz.pc_write, 1);
    cmp("post-boot IF_flush literal", hz.IF_flush, 0);
    vec("run_final", 0, OPC_I, 0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
